// File: rtl/mem_stage_if.sv
// Bundle between the EXE/MEM register, the memory stage and the MEM/WB register.
// master = EXE/MEM side driving the request, slave = the memory stage itself.
interface mem_stage_if;
    logic        mem_read;
    logic        mem_write;
    logic        wb_en;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] st_val;

    logic        ready;
    logic [31:0] mem_data;
    logic        wb_en_out;
    logic        mem_read_out;
    logic [4:0]  dest_out;
    logic [31:0] alu_result_out;

    modport master (
        output mem_read, mem_write, wb_en, dest, alu_result, st_val,
        input  ready, mem_data, wb_en_out, mem_read_out, dest_out, alu_result_out
    );

    modport slave (
        input  mem_read, mem_write, wb_en, dest, alu_result, st_val,
        output ready, mem_data, wb_en_out, mem_read_out, dest_out, alu_result_out
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: multi-cycle load/store against an internal word memory,
// stalling upstream through ready while an access is in flight.
module mem_stage #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 4,
    parameter int BASE    = 1024
) (
    input  logic       clock,
    input  logic       reset,
    mem_stage_if.slave bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
    localparam logic [31:0] BASE_ADDR = 32'(BASE);
    localparam logic [3:0]  CNT_START = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [3:0]    count;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx_q;
    logic [31:0]   data_q;
    logic          in_range_q;
    logic          store_q;
    logic          both_q;

    logic          req;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          commit;

    assign req      = bus.mem_read | bus.mem_write;
    assign offset   = bus.alu_result - BASE_ADDR;
    assign in_range = (offset < SPAN);
    assign idx      = offset[AW+1:2];
    assign commit   = (state == BUSY) && (count == 4'd1);

    // ready only sees req while idle; during DONE the held request is the old one
    assign bus.ready = (state == IDLE) ? ~req : (state == DONE);

    assign bus.wb_en_out      = bus.wb_en;
    assign bus.mem_read_out   = bus.mem_read;
    assign bus.dest_out       = bus.dest;
    assign bus.alu_result_out = bus.alu_result;

    // Control FSM; address, data and kind are captured at acceptance so later
    // input changes cannot disturb the commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= 4'd0;
            idx_q        <= '0;
            data_q       <= 32'd0;
            in_range_q   <= 1'b0;
            store_q      <= 1'b0;
            both_q       <= 1'b0;
            bus.mem_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state      <= BUSY;
                        count      <= CNT_START;
                        idx_q      <= idx;
                        data_q     <= bus.st_val;
                        in_range_q <= in_range;
                        store_q    <= bus.mem_write;
                        both_q     <= bus.mem_read & bus.mem_write;
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (commit) begin
                        state <= DONE;
                        if (store_q) begin
                            if (both_q) begin
                                bus.mem_data <= 32'd0;
                            end
                        end else begin
                            bus.mem_data <= in_range_q ? mem[idx_q] : 32'd0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data memory; cleared on reset, written only on a committing in-range store.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (commit && store_q && in_range_q) begin
            mem[idx_q] <= data_q;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against an array-based reference
// model of the memory and the load-result register.
module tb_mem_stage;
    localparam int DEPTH   = 64;
    localparam int LATENCY = 4;
    localparam int BASE    = 1024;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_md;

    mem_stage_if bus();

    mem_stage #(
        .DEPTH(DEPTH),
        .LATENCY(LATENCY),
        .BASE(BASE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        model_md = 32'd0;
    endtask

    task automatic model_access(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off;
        bit          hit;
        int          word;
        off  = addr - 32'(BASE);
        hit  = (off < 32'(DEPTH * 4));
        word = hit ? int'(off / 4) : 0;
        if (wr) begin
            if (hit) model_mem[word] = data;
            if (rd) model_md = 32'd0;
        end else begin
            model_md = hit ? model_mem[word] : 32'd0;
        end
    endtask

    task automatic check_passthrough(input string tag);
        checks++;
        if ({bus.wb_en_out, bus.mem_read_out, bus.dest_out, bus.alu_result_out} !==
            {bus.wb_en, bus.mem_read, bus.dest, bus.alu_result}) begin
            errors++;
            $display("[TB] FAIL %s passthrough: got %b/%b/%h/%h expected %b/%b/%h/%h", tag,
                     bus.wb_en_out, bus.mem_read_out, bus.dest_out, bus.alu_result_out,
                     bus.wb_en, bus.mem_read, bus.dest, bus.alu_result);
        end
    endtask

    // One full access: LATENCY stalled cycles then one DONE cycle, checked every cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input bit perturb, input string tag);
        logic [31:0] old_md;
        logic [31:0] exp_md;
        logic [31:0] want_md;
        old_md = model_md;
        model_access(rd, wr, addr, data);
        exp_md = model_md;
        for (int c = 0; c <= LATENCY; c++) begin
            @(posedge clock);
            #1;
            if (c == 0) begin
                bus.mem_read   = rd;
                bus.mem_write  = wr;
                bus.alu_result = addr;
                bus.st_val     = data;
                bus.wb_en      = 1'($urandom);
                bus.dest       = 5'($urandom);
            end else if (perturb && c == 2) begin
                bus.alu_result = $urandom;
                bus.st_val     = $urandom;
                bus.wb_en      = ~bus.wb_en;
                bus.dest       = 5'($urandom);
            end
            @(negedge clock);
            checks++;
            if (bus.ready !== 1'(c == LATENCY)) begin
                errors++;
                $display("[TB] FAIL %s ready cycle %0d: got %b expected %b",
                         tag, c, bus.ready, 1'(c == LATENCY));
            end
            want_md = (c == LATENCY) ? exp_md : old_md;
            checks++;
            if (bus.mem_data !== want_md) begin
                errors++;
                $display("[TB] FAIL %s mem_data cycle %0d: got %h expected %h",
                         tag, c, bus.mem_data, want_md);
            end
            check_passthrough(tag);
        end
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clock);
        #1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.wb_en      = 1'($urandom);
        bus.dest       = 5'($urandom);
        bus.alu_result = $urandom;
        bus.st_val     = $urandom;
        @(negedge clock);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s idle ready: got %b expected 1", tag, bus.ready);
        end
        checks++;
        if (bus.mem_data !== model_md) begin
            errors++;
            $display("[TB] FAIL %s idle mem_data: got %h expected %h", tag, bus.mem_data, model_md);
        end
        check_passthrough(tag);
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #1;
        reset         = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic sweep_memory(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            do_access(1'b1, 1'b0, 32'(BASE + 4 * i), $urandom, 1'b0, tag);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) idle_cycle("reset_idle");
    endtask

    task automatic test_store_load();
        do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0, "store_1032");
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, "load_1032");
        idle_cycle("after_store_load");
    endtask

    task automatic test_out_of_range();
        apply_reset();
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, "load_after_reset");
        do_access(1'b0, 1'b1, 32'd1044, 32'h12345678, 1'b0, "store_1044");
        do_access(1'b1, 1'b0, 32'd1044, 32'h0, 1'b0, "load_1044");
        do_access(1'b1, 1'b0, 32'd1000, 32'h0, 1'b0, "load_below_base");
        do_access(1'b0, 1'b1, 32'(BASE + DEPTH * 4), 32'hCAFEF00D, 1'b0, "store_past_end");
        do_access(1'b0, 1'b1, 32'd1020, 32'hBAADF00D, 1'b0, "store_below_base");
        sweep_memory("sweep_oor");
    endtask

    task automatic test_reset_busy();
        @(posedge clock);
        #1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b1;
        bus.alu_result = 32'd1036;
        bus.st_val     = 32'hA5A5A5A5;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++;
            if (bus.ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_busy ready cycle %0d: got %b expected 0", c, bus.ready);
            end
            if (c == 0) begin
                @(posedge clock);
                #1;
            end
        end
        @(posedge clock);
        #1;
        reset         = 1'b1;
        bus.mem_write = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
        @(negedge clock);
        checks++;
        if (bus.ready !== 1'b1 || bus.mem_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_busy idle: got ready %b data %h expected 1/00000000",
                     bus.ready, bus.mem_data);
        end
        idle_cycle("reset_busy_idle");
        do_access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, "reset_busy_load");
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b1, 32'd1024, 32'd1, 1'b0, "b2b_store0");
        do_access(1'b0, 1'b1, 32'd1028, 32'd2, 1'b0, "b2b_store1");
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, "b2b_load0");
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, "b2b_load1");
    endtask

    task automatic test_both_asserted();
        do_access(1'b0, 1'b1, 32'd1032, 32'h55, 1'b0, "both_prep_store");
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, "both_prep_load");
        do_access(1'b1, 1'b1, 32'd1040, 32'd7, 1'b0, "both_store_1040");
        do_access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, "both_load_1040");
    endtask

    task automatic test_random();
        int          kind;
        logic [31:0] addr;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 4));
            addr = 32'(BASE - 16) + 32'($urandom_range(0, DEPTH * 4 + 31));
            case (kind)
                0:       idle_cycle("rand_idle");
                1, 2:    do_access(1'b0, 1'b1, addr, $urandom, 1'($urandom), "rand_store");
                3:       do_access(1'b1, 1'b0, addr, $urandom, 1'($urandom), "rand_load");
                default: do_access(1'b1, 1'b1, addr, $urandom, 1'($urandom), "rand_both");
            endcase
        end
        sweep_memory("sweep_rand");
    endtask

    initial begin
        reset          = 1'b1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.wb_en      = 1'b0;
        bus.dest       = 5'd0;
        bus.alu_result = 32'd0;
        bus.st_val     = 32'd0;
        model_clear();

        test_reset();
        test_store_load();
        test_out_of_range();
        test_reset_busy();
        test_back_to_back();
        test_both_asserted();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, sitting between the EXE/MEM and MEM/WB pipeline registers. It executes load/store operations against an internal word-addressed data memory with a fixed multi-cycle access latency. It drives `ready` low to freeze the upstream pipeline while an access is in flight. Control and ALU fields are passed through to the MEM/WB register unchanged.

## Interface
- `DEPTH`, 64: data memory size in 32-bit words (power of two).
- `LATENCY`, 4: cycles from request acceptance to completion; legal range 2..15.
- `BASE`, 1024: byte address mapped to word 0.

- `clock`  in  1: sole clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `mem_read`  in  1: load request.
- `mem_write`  in  1: store request.
- `wb_en`  in  1: writeback enable from EXE/MEM.
- `dest`  in  5: destination register from EXE/MEM.
- `alu_result`  in  32: byte address for load/store, or pass-through value.
- `st_val`  in  32: store data.
- `ready`  out  1: 1 = stage may advance; 0 = upstream must hold all inputs stable.
- `mem_data`  out  32: registered load result.
- `wb_en_out`, `mem_read_out`, `dest_out`, `alu_result_out`  out  1/1/5/32: combinational pass-through of the matching inputs.

## Operation
- Request: `req = mem_read | mem_write`. If both are 1, it is a store; `mem_read` is ignored for the access and `mem_data` loads 0.
- Address: `offset = alu_result - BASE` (32-bit, wraps). `offset` is in range iff `offset < DEPTH*4`. Word index = `offset[log2(DEPTH)+1:2]`; bits [1:0] are ignored.
- Out-of-range store: memory is unchanged. Out-of-range load: `mem_data` = 0. Neither case raises an error, and the timing is identical to an in-range access.
- FSM:
  - IDLE: if `req` = 0, `ready` = 1 and the FSM stays in IDLE. If `req` = 1, `ready` = 0, the counter loads `LATENCY-1` and the FSM goes to BUSY.
  - BUSY: `ready` = 0 and the counter decrements. When the counter reaches 1, the access commits on that edge: the store writes memory, or the load captures `mem_data`. The FSM then goes to DONE.
  - DONE: `ready` = 1 for exactly one cycle, then the FSM returns to IDLE. A `req` present in DONE is not started; it is the old request still being consumed. The next request is detected in IDLE on the following cycle.
- `mem_data` holds its value until the next load commit or reset. Stores do not change it, except the both-asserted case, which loads 0.
- Reset: FSM goes to IDLE, counter to 0, `mem_data` to 0, all memory words to 0, `ready` = 1. Reset during BUSY aborts the access: no memory write and no `mem_data` update.
- Pass-through outputs are purely combinational and unaffected by the FSM.

## Timing
- A request first visible in cycle t (IDLE) gives `ready` = 0 in cycles t .. t+LATENCY-1 and `ready` = 1 in cycle t+LATENCY (DONE).
- `mem_data` is valid from cycle t+LATENCY onward.
- The pipeline advances at the end of cycle t+LATENCY. Total occupancy is LATENCY+1 cycles.
- A new request presented in cycle t+LATENCY+1 starts immediately.
- Non-memory instructions take zero extra cycles: `ready` stays 1 throughout.
- The only combinational path from inputs to `ready` is `req` gated by IDLE state. There is no combinational path from inputs to `mem_data`.
- Upstream holding inputs stable while `ready` = 0 is required. Inputs changed mid-access do not affect the committed address or data, because both are latched at request acceptance.

## Test plan
- Reset, then idle with `req` = 0 for 5 cycles → `ready` = 1 and `mem_data` = 0 every cycle.
- Store 0xDEADBEEF to 1032 (`LATENCY` = 4), accepted at cycle 0 → `ready` = 0 in cycles 0–3 and 1 in cycle 4. Then load from 1032 → `mem_data` = 0xDEADBEEF in cycle 4 of the load.
- Load from 1028 after reset → `mem_data` = 0. Load from 1000 (out of range) after a prior load of 0x12345678 → `mem_data` = 0. Store to 1024+DEPTH*4 → every word is unchanged.
- Store 0xA5A5A5A5 to 1036, then assert `reset` in BUSY cycle 2 → the FSM returns to IDLE. A subsequent load from 1036 returns 0.
- Back-to-back stores to 1024 and 1028 (values 1 and 2), then loads of both → each load returns its stored value. Each access shows exactly 4 cycles of `ready` = 0 followed by 1 cycle of `ready` = 1.
- Assert `mem_read` and `mem_write` together, storing 7 to 1040 → memory[4] = 7 and `mem_data` = 0. Throughout the test, `wb_en_out`, `dest_out` and `alu_result_out` equal their inputs.
